// File: rtl/ecall_sequencer_if.sv
// ECALL sequencer signal bundle: commit handshake, register-file ports,
// ecall-unit request/response and fetch redirect.
interface ecall_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  ecall_valid;
    logic [DATA_WIDTH-1:0] ecall_pc;
    logic                  ecall_ready;
    logic                  stores_pending;
    logic [4:0]            rf_rd_addr;
    logic [DATA_WIDTH-1:0] rf_rd_data;
    logic [DATA_WIDTH-1:0] a0;
    logic [DATA_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] a2;
    logic [DATA_WIDTH-1:0] a3;
    logic [DATA_WIDTH-1:0] a4;
    logic [DATA_WIDTH-1:0] a5;
    logic [DATA_WIDTH-1:0] a6;
    logic [DATA_WIDTH-1:0] a7;
    logic                  trigger;
    logic                  flush;
    logic [DATA_WIDTH-1:0] result;
    logic                  rf_wr_en;
    logic [4:0]            rf_wr_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  stall;
    logic                  err;

    // Sequencer side.
    modport master (
        input  ecall_valid, ecall_pc, stores_pending, rf_rd_data, flush, result,
        output ecall_ready, rf_rd_addr, a0, a1, a2, a3, a4, a5, a6, a7, trigger,
        output rf_wr_en, rf_wr_addr, rf_wr_data, redirect_valid, redirect_pc, stall, err
    );

    // Pipeline / regfile / ecall-unit side.
    modport slave (
        output ecall_valid, ecall_pc, stores_pending, rf_rd_data, flush, result,
        input  ecall_ready, rf_rd_addr, a0, a1, a2, a3, a4, a5, a6, a7, trigger,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, redirect_valid, redirect_pc, stall, err
    );
endinterface

// File: rtl/ecall_sequencer.sv
// ECALL initiator: stall front end, drain stores, read a0..a7, trigger the
// ecall unit, wait for flush (with timeout), write back a0 and redirect fetch.
module ecall_sequencer #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    ecall_sequencer_if.master bus
);
    localparam int unsigned TmoW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(RESP_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StDrain, StRead, StFire, StWait, StWb} state_e;

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [TmoW-1:0]       tmo_inc;
    logic                  tmo_hit_q, tmo_hit_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] args_q [8];
    logic [DATA_WIDTH-1:0] args_d [8];

    assign tmo_inc        = tmo_q + TmoW'(1);
    assign bus.rf_wr_data = res_q;
    assign bus.a0         = args_q[0];
    assign bus.a1         = args_q[1];
    assign bus.a2         = args_q[2];
    assign bus.a3         = args_q[3];
    assign bus.a4         = args_q[4];
    assign bus.a5         = args_q[5];
    assign bus.a6         = args_q[6];
    assign bus.a7         = args_q[7];

    // State register; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            tmo_q     <= '0;
            tmo_hit_q <= 1'b0;
            pc_q      <= '0;
            res_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                args_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            tmo_hit_q <= tmo_hit_d;
            pc_q      <= pc_d;
            res_q     <= res_d;
            args_q    <= args_d;
        end
    end

    // Next-state logic and Moore/Mealy outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        tmo_hit_d = tmo_hit_q;
        pc_d      = pc_q;
        res_d     = res_q;
        args_d    = args_q;

        bus.ecall_ready    = 1'b0;
        bus.rf_rd_addr     = 5'd0;
        bus.trigger        = 1'b0;
        bus.rf_wr_en       = 1'b0;
        bus.rf_wr_addr     = 5'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = (state_q != StIdle);
        bus.err            = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.ecall_valid) begin
                    pc_d    = bus.ecall_pc;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!bus.stores_pending) begin
                    idx_d   = 4'd0;
                    state_d = StRead;
                end
            end
            StRead: begin
                // Address goes out at idx, data returns at idx+1.
                if (idx_q < 4'd8) begin
                    bus.rf_rd_addr = 5'd10 + 5'(idx_q);
                end
                // idx 8 wraps [2:0] to 0, so 0-1 lands on a7.
                if (idx_q != 4'd0) begin
                    args_d[idx_q[2:0] - 3'd1] = bus.rf_rd_data;
                end
                if (idx_q == 4'd8) begin
                    state_d = StFire;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StFire: begin
                bus.trigger = 1'b1;
                tmo_d       = '0;
                tmo_hit_d   = 1'b0;
                state_d     = StWait;
            end
            StWait: begin
                // Flush takes priority over a timeout landing in the same cycle.
                if (bus.flush) begin
                    res_d   = bus.result;
                    state_d = StWb;
                end else if (tmo_inc == TmoMax) begin
                    bus.err   = 1'b1;
                    tmo_hit_d = 1'b1;
                    tmo_d     = tmo_inc;
                    state_d   = StWb;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StWb: begin
                bus.ecall_ready    = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = pc_q + DATA_WIDTH'(4);
                if (!tmo_hit_q) begin
                    bus.rf_wr_en   = 1'b1;
                    bus.rf_wr_addr = 5'd10;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_ecall_sequencer.sv
// Self-checking bench for ecall_sequencer: directed and randomized ECALLs
// checked cycle by cycle against a transaction-level timing model.
module tb_ecall_sequencer;
    localparam int unsigned DW  = 64;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ecall_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    ecall_sequencer #(.DATA_WIDTH(DW), .RESP_TIMEOUT(TMO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] rf_mem [32];

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] arg_out(input int k);
        case (k)
            0: return bus.a0;
            1: return bus.a1;
            2: return bus.a2;
            3: return bus.a3;
            4: return bus.a4;
            5: return bus.a5;
            6: return bus.a6;
            default: return bus.a7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rf();
        for (int i = 10; i < 18; i++) rf_mem[i] = rand64();
    endtask

    // One ECALL transaction, cycle 0 = accept cycle.
    // pend: cycles stores_pending stays high after accept.
    // fd: flush delay after trigger (1..TMO), 0 = never respond.
    // abort_at: cycle in which reset is pulled low (0 = no abort).
    // hold_next: from cycle 2 on, raise ecall_valid with next_pc while busy.
    task automatic run_ecall(input logic [63:0] pc, input int pend, input int fd,
                             input bit noise, input int abort_at, input bit hold_next,
                             input logic [63:0] next_pc, input logic [63:0] res);
        int          trig, wbc, last;
        bit          flushed, live, wb;
        logic [4:0]  prev_addr;
        logic [63:0] exp_addr;
        trig    = pend + 11;
        flushed = (fd >= 1 && fd <= int'(TMO));
        wbc     = flushed ? trig + fd + 1 : trig + int'(TMO) + 1;
        last    = (abort_at > 0) ? abort_at + 4 : wbc;
        prev_addr = 5'd0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            reset = (abort_at > 0 && c == abort_at) ? 1'b0 : 1'b1;
            if (c == 0) begin
                bus.ecall_valid = 1'b1;
                bus.ecall_pc    = pc;
            end else if (hold_next && c >= 2) begin
                bus.ecall_valid = 1'b1;
                bus.ecall_pc    = next_pc;
            end else begin
                bus.ecall_valid = 1'b0;
                bus.ecall_pc    = rand64();
            end
            bus.stores_pending = (c >= 1 && c <= pend);
            bus.rf_rd_data     = rf_mem[prev_addr];
            if (flushed && c == trig + fd) begin
                bus.flush  = 1'b1;
                bus.result = res;
            end else begin
                bus.result = rand64();
                if (abort_at > 0 && c > abort_at) bus.flush = 1'b1;
                else if (noise && c <= trig)      bus.flush = 1'($urandom_range(0, 1));
                else                              bus.flush = 1'b0;
            end
            #1;
            prev_addr = bus.rf_rd_addr;
            live      = (abort_at == 0) || (c <= abort_at);
            wb        = live && (c == wbc);
            exp_addr  = (live && c >= pend + 2 && c <= pend + 9) ? 64'(10 + c - pend - 2) : 64'd0;
            check($sformatf("stall c%0d", c), 64'(bus.stall), 64'(live && c >= 1 && c <= wbc));
            check($sformatf("trigger c%0d", c), 64'(bus.trigger), 64'(live && c == trig));
            check($sformatf("err c%0d", c), 64'(bus.err),
                  64'(live && !flushed && c == trig + int'(TMO)));
            check($sformatf("ecall_ready c%0d", c), 64'(bus.ecall_ready), 64'(wb));
            check($sformatf("redirect_valid c%0d", c), 64'(bus.redirect_valid), 64'(wb));
            check($sformatf("rf_wr_en c%0d", c), 64'(bus.rf_wr_en), 64'(wb && flushed));
            check($sformatf("rf_rd_addr c%0d", c), 64'(bus.rf_rd_addr), exp_addr);
            if (live && c == trig) begin
                for (int k = 0; k < 8; k++) check($sformatf("a%0d", k), arg_out(k), rf_mem[10 + k]);
            end
            if (wb) begin
                check("redirect_pc", bus.redirect_pc, pc + 64'd4);
                check("rf_wr_addr", 64'(bus.rf_wr_addr), flushed ? 64'd10 : 64'd0);
                if (flushed) check("rf_wr_data", bus.rf_wr_data, res);
            end
            if (abort_at > 0 && c == last) begin
                for (int k = 0; k < 8; k++) check($sformatf("abort a%0d", k), arg_out(k), 64'd0);
            end
        end
    endtask

    initial begin
        logic [63:0] pc2;
        for (int i = 0; i < 32; i++) rf_mem[i] = 64'd0;
        bus.ecall_valid    = 1'b0;
        bus.ecall_pc       = '0;
        bus.stores_pending = 1'b0;
        bus.rf_rd_data     = '0;
        bus.flush          = 1'b0;
        bus.result         = '0;
        reset              = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state.
        check("rst stall", 64'(bus.stall), 64'd0);
        check("rst trigger", 64'(bus.trigger), 64'd0);
        check("rst ready", 64'(bus.ecall_ready), 64'd0);
        check("rst wr_en", 64'(bus.rf_wr_en), 64'd0);
        check("rst redirect", 64'(bus.redirect_valid), 64'd0);
        check("rst redirect_pc", bus.redirect_pc, 64'd0);
        check("rst err", 64'(bus.err), 64'd0);
        check("rst rd_addr", 64'(bus.rf_rd_addr), 64'd0);
        check("rst wr_data", bus.rf_wr_data, 64'd0);
        for (int k = 0; k < 8; k++) check($sformatf("rst a%0d", k), arg_out(k), 64'd0);
        reset = 1'b1;

        // 1: minimum latency, x10..x17 = 1..8, result 0x55.
        for (int i = 0; i < 8; i++) rf_mem[10 + i] = 64'(i + 1);
        run_ecall(64'h0000_0000_0000_1000, 0, 1, 1'b0, 0, 1'b0, 64'd0, 64'h55);
        // 2: stores pending for 5 cycles.
        fill_rf();
        run_ecall(64'h0000_0000_8000_0040, 5, 1, 1'b0, 0, 1'b0, 64'd0, rand64());
        // 3: no response -> timeout.
        fill_rf();
        run_ecall(64'h0000_0000_0000_2000, 0, 0, 1'b0, 0, 1'b0, 64'd0, rand64());
        // 4: reset during WAIT, flush afterwards.
        fill_rf();
        run_ecall(64'h0000_0000_0000_3000, 0, 5, 1'b0, 14, 1'b0, 64'd0, rand64());
        // 5: wrapping PC, second ECALL raised while busy.
        fill_rf();
        pc2 = 64'h0000_0000_0040_0010;
        run_ecall(64'hFFFF_FFFF_FFFF_FFFC, 2, 3, 1'b0, 0, 1'b1, pc2, rand64());
        fill_rf();
        run_ecall(pc2, 0, 2, 1'b0, 0, 1'b0, 64'd0, rand64());
        // 6: spurious flush in IDLE and READ.
        fill_rf();
        run_ecall(64'h0000_0000_0000_4000, 1, 4, 1'b1, 0, 1'b0, 64'd0, rand64());
        // Timeout boundary: flush on the last waiting cycle and the one before.
        fill_rf();
        run_ecall(64'h0000_0000_0000_5000, 0, 16, 1'b0, 0, 1'b0, 64'd0, rand64());
        fill_rf();
        run_ecall(64'h0000_0000_0000_6000, 0, 15, 1'b0, 0, 1'b0, 64'd0, rand64());
        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            fill_rf();
            run_ecall({rand64()} & ~64'h3, int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), 0, 1'b0,
                      64'd0, rand64());
        end
        @(negedge clk);
        bus.ecall_valid = 1'b0;
        bus.flush       = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
